// File: rtl/avalon_bus_arbiter.sv
// ============================================================================
// Module   : avalon_bus_arbiter
// Purpose  : 2:1 Avalon-MM arbiter (IFU/LSU onto one memory port) with
//            grant hold during waitrequest and tagged read-data steering.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package avalon_pkg;
  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic        waitrequest;
    logic [31:0] readdata;
  } avalon_resp_t;
endpackage

module avalon_bus_arbiter
  import avalon_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter bit ARB_MODE     = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  avalon_req_t  ibus_avalon_req,
  output avalon_resp_t ibus_avalon_resp,
  input  avalon_req_t  dbus_avalon_req,
  output avalon_resp_t dbus_avalon_resp,
  output avalon_req_t  mem_avalon_req,
  input  avalon_resp_t mem_avalon_resp
);

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t             r_state;
  logic                    r_owner;
  logic                    r_last_grant;
  logic [READ_LATENCY-1:0] r_tag_vld;
  logic [READ_LATENCY-1:0] r_tag_own;

  logic        w_ireq;
  logic        w_dreq;
  logic        w_sel;
  logic        w_sel_active;
  logic        w_fire;
  logic        w_rd_fire;
  avalon_req_t w_sel_req;

  assign w_ireq = ibus_avalon_req.read | ibus_avalon_req.write;
  assign w_dreq = dbus_avalon_req.read | dbus_avalon_req.write;

  // Selection is purely combinational so a lone requester is granted with no bubble.
  always_comb begin
    w_sel = r_last_grant;
    if (r_state == LOCKED) begin
      w_sel = r_owner;
    end else if (w_ireq && !w_dreq) begin
      w_sel = 1'b0;
    end else if (w_dreq && !w_ireq) begin
      w_sel = 1'b1;
    end else if (w_ireq && w_dreq) begin
      w_sel = ARB_MODE ? 1'b1 : ~r_last_grant;
    end
  end

  assign w_sel_req    = w_sel ? dbus_avalon_req : ibus_avalon_req;
  assign w_sel_active = (w_sel_req.read | w_sel_req.write) & ~rst;
  assign w_fire       = w_sel_active & ~mem_avalon_resp.waitrequest;
  assign w_rd_fire    = w_fire & w_sel_req.read;

  always_comb begin
    mem_avalon_req       = w_sel_req;
    mem_avalon_req.read  = w_sel_req.read  & (w_ireq | w_dreq) & ~rst;
    mem_avalon_req.write = w_sel_req.write & (w_ireq | w_dreq) & ~rst;
  end

  always_comb begin
    ibus_avalon_resp.waitrequest = rst | ~w_ireq | w_sel  | mem_avalon_resp.waitrequest;
    dbus_avalon_resp.waitrequest = rst | ~w_dreq | ~w_sel | mem_avalon_resp.waitrequest;
    ibus_avalon_resp.readdata    = '0;
    dbus_avalon_resp.readdata    = '0;
    if (!rst && r_tag_vld[READ_LATENCY-1]) begin
      if (r_tag_own[READ_LATENCY-1]) begin
        dbus_avalon_resp.readdata = mem_avalon_resp.readdata;
      end else begin
        ibus_avalon_resp.readdata = mem_avalon_resp.readdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= UNLOCKED;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_tag_vld    <= '0;
      r_tag_own    <= '0;
    end else begin
      case (r_state)
        UNLOCKED: begin
          if (w_sel_active && mem_avalon_resp.waitrequest) begin
            r_state <= LOCKED;
            r_owner <= w_sel;
          end
        end
        LOCKED: begin
          if (w_fire) begin
            r_state <= UNLOCKED;
          end
        end
        default: r_state <= UNLOCKED;
      endcase

      if (w_fire) begin
        r_last_grant <= w_sel;
      end

      // Tag pipe never stalls: the slave returns data at a fixed latency.
      r_tag_vld[0] <= w_rd_fire;
      r_tag_own[0] <= w_sel;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
      end
    end
  end

endmodule

`default_nettype wire
